// File: rtl/puf_challenge_driver.sv
// puf_challenge_driver: LFSR-driven arbiter PUF initiator; launches races, samples responses, packs a response word.
// Ports: clk, rst_n (sync, active low); start/seed_load/seed from controller;
// in0/in1/control to the arbiter; arb_out/arb_out_inv back from it (async);
// busy/done/response/err_count to the controller.
module puf_challenge_driver #(
  parameter int CHAL_W = 128,
  parameter int RESP_BITS = 32,
  parameter int SETTLE_CYC = 8,
  parameter logic [CHAL_W-1:0] SEED = 128'hc71f2e46cc9dc3bfdd47048bc4bdce79
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 seed_load,
  input  logic [CHAL_W-1:0]    seed,
  output logic                 in0,
  output logic                 in1,
  output logic [CHAL_W-1:0]    control,
  input  logic                 arb_out,
  input  logic                 arb_out_inv,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic [7:0]           err_count
);
  localparam int CW = $clog2(SETTLE_CYC);
  typedef enum logic [2:0] {IDLE, SETUP, LAUNCH, SAMPLE, RELAX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0] bit_q, bit_d;
  logic [CHAL_W-1:0] lfsr_q, lfsr_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic [7:0] err_q, err_d;
  logic [1:0] a_q, ai_q;
  logic in_q, in_d;
  logic cnt_last, bit_last, go, smp;
  assign cnt_last = cnt_q == CW'(SETTLE_CYC - 1);
  assign bit_last = bit_q == 6'(RESP_BITS - 1);
  assign go = state_q == IDLE && start;
  assign smp = state_q == SAMPLE;
  always_ff @(posedge clk)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? SETUP : IDLE;
      SETUP:   state_d = LAUNCH;
      LAUNCH:  state_d = cnt_last ? SAMPLE : LAUNCH;
      SAMPLE:  state_d = RELAX;
      RELAX:   state_d = cnt_last ? (bit_last ? DONE : SETUP) : RELAX;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // in0/in1 come from a flop fed by the next state so the launch lines never glitch
  always_comb begin
    in_d = state_d == LAUNCH || state_d == SAMPLE;
    busy = state_q != IDLE && state_q != DONE;
    done = state_q == DONE;
  end
  always_comb begin
    cnt_d = (state_q == LAUNCH || state_q == RELAX) && state_d == state_q ? cnt_q + CW'(1) : '0;
    bit_d = go ? '0 : state_q == RELAX && state_d == SETUP ? bit_q + 6'd1 : bit_q;
    // an all-zero seed would lock the LFSR, so it is replaced by 1
    lfsr_d = state_q == IDLE && seed_load ? (seed == '0 ? CHAL_W'(1) : seed)
           : smp ? {lfsr_q[126:0], lfsr_q[127] ^ lfsr_q[125] ^ lfsr_q[100] ^ lfsr_q[98]}
           : lfsr_q;
    resp_d = go ? '0 : smp ? {resp_q[RESP_BITS-2:0], a_q[1]} : resp_q;
    err_d = go ? '0 : smp && a_q[1] == ai_q[1] && err_q != 8'hff ? err_q + 8'd1 : err_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt_q <= '0;
      bit_q <= '0;
      lfsr_q <= SEED;
      resp_q <= '0;
      err_q <= '0;
      a_q <= '0;
      ai_q <= '0;
      in_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      lfsr_q <= lfsr_d;
      resp_q <= resp_d;
      err_q <= err_d;
      a_q <= {a_q[0], arb_out};
      ai_q <= {ai_q[0], arb_out_inv};
      in_q <= in_d;
    end
  assign in0 = in_q;
  assign in1 = in_q;
  assign control = lfsr_q;
  assign response = resp_q;
  assign err_count = err_q;
endmodule
